// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/grant bundle shared by the arbiter, requesters and memory
interface mem_port_arbiter_if;
  logic req1;
  logic req2;
  logic memReady;
  logic sel1;
  logic sel2;
  logic gnt1;
  logic gnt2;
  logic memReq;
  logic busy;
  logic timeoutErr;

  modport master (
    input  req1, req2, memReady,
    output sel1, sel2, gnt1, gnt2, memReq, busy, timeoutErr
  );

  modport slave (
    output req1, req2, memReady,
    input  sel1, sel2, gnt1, gnt2, memReq, busy, timeoutErr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for one shared memory port
// A grant holds until memReady or the watchdog fires; every grant is followed by one idle cycle.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE1 = 2'd1,
    SERVE2 = 2'd2
  } state_e;

  localparam bit               WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last2_q, last2_d;
  logic             terr_q, terr_d;
  logic             sel1_q, sel2_q, memreq_q, busy_q;
  logic             timeout_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    last2_d     = last2_q;
    terr_d      = 1'b0;
    timeout_hit = WDOG_EN && (cnt_q == CNT_LAST) && !bus.memReady;

    unique case (state_q)
      IDLE: begin
        // last2_q set means requester 2 won last time, so requester 1 takes a tie
        if (bus.req1 && (!bus.req2 || last2_q)) begin
          state_d = SERVE1;
          last2_d = 1'b0;
        end else if (bus.req2) begin
          state_d = SERVE2;
          last2_d = 1'b1;
        end
      end
      SERVE1, SERVE2: begin
        if (bus.memReady) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last2_q  <= 1'b1;
      terr_q   <= 1'b0;
      sel1_q   <= 1'b0;
      sel2_q   <= 1'b0;
      memreq_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last2_q  <= last2_d;
      terr_q   <= terr_d;
      sel1_q   <= (state_d == SERVE1);
      sel2_q   <= (state_d == SERVE2);
      memreq_q <= (state_d != IDLE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.sel1       = sel1_q;
  assign bus.gnt1       = sel1_q;
  assign bus.sel2       = sel2_q;
  assign bus.gnt2       = sel2_q;
  assign bus.memReq     = memreq_q;
  assign bus.busy       = busy_q;
  assign bus.timeoutErr = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int TMO_A = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.TIMEOUT(TMO_A), .CNT_W(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.TIMEOUT(0),     .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r1, input bit r2, input bit mr, input bit rs);
    bus_a.req1     = r1;
    bus_a.req2     = r2;
    bus_a.memReady = mr;
    rst            = rs;
  endtask

  // {sel1, sel2, gnt1, gnt2, memReq, busy, timeoutErr}
  function automatic logic [6:0] obs_a();
    return {bus_a.sel1, bus_a.sel2, bus_a.gnt1, bus_a.gnt2, bus_a.memReq, bus_a.busy, bus_a.timeoutErr};
  endfunction

  task automatic test_reset();
    drive(1, 1, 0, 1);
    tick;
    tick;
    total++;
    if (obs_a() !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", obs_a(), 7'b0);
    end
    drive(1, 1, 0, 0);
    tick;
    total++;
    if (obs_a() !== 7'b1010110) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want %b", obs_a(), 7'b1010110);
    end
    drive(0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_single();
    int hi, s1, post_busy;
    hi = 0; s1 = 0; post_busy = -1;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus_a.sel1) s1++;
      if (bus_a.gnt2 && bus_a.sel2 && bus_a.memReq) begin
        hi++;
        if (hi == 3) drive(0, 0, 1, 0);
        else drive(0, 1, 0, 0);
      end else begin
        if (hi == 3 && post_busy < 0) post_busy = int'(bus_a.busy);
        drive(0, 0, 0, 0);
      end
    end
    total++;
    if (hi !== 3) begin
      bad++;
      $display("FAIL single_grant_len: got %0d want %0d", hi, 3);
    end
    total++;
    if (s1 !== 0) begin
      bad++;
      $display("FAIL single_sel1_seen: got %0d want %0d", s1, 0);
    end
    total++;
    if (post_busy !== 0) begin
      bad++;
      $display("FAIL single_idle_after: got %0d want %0d", post_busy, 0);
    end
  endtask

  task automatic test_contention();
    int order[4];
    int ng, age, idle_run, gap_bad, both;
    ng = 0; age = 0; idle_run = 0; gap_bad = 0; both = 0;
    for (int k = 0; k < 4; k++) order[k] = 0;
    drive(1, 1, 0, 0);
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick;
      if (bus_a.sel1 && bus_a.sel2) both++;
      if (bus_a.gnt1 || bus_a.gnt2) begin
        if (age == 0) begin
          order[ng] = bus_a.gnt1 ? 1 : 2;
          if (ng > 0 && idle_run != 1) gap_bad++;
          ng++;
        end
        age++;
        idle_run = 0;
        if (age == 2) drive(1, 1, 1, 0);
        else drive(1, 1, 0, 0);
      end else begin
        age = 0;
        idle_run++;
        drive(1, 1, 0, 0);
      end
    end
    total++;
    if (ng !== 4) begin
      bad++;
      $display("FAIL contention_grant_count: got %0d want %0d", ng, 4);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (order[k] !== ((k % 2) + 1)) begin
        bad++;
        $display("FAIL contention_order[%0d]: got %0d want %0d", k, order[k], (k % 2) + 1);
      end
    end
    total++;
    if (gap_bad !== 0) begin
      bad++;
      $display("FAIL contention_turnaround: got %0d bad gaps want %0d", gap_bad, 0);
    end
    total++;
    if (both !== 0) begin
      bad++;
      $display("FAIL contention_both_sel: got %0d want %0d", both, 0);
    end
    drive(0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_timeout();
    int n_g, n_t, t_at;
    n_g = 0; n_t = 0; t_at = -1;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick;
      drive(0, 0, 0, 0);
      if (bus_a.gnt1) n_g++;
      if (bus_a.timeoutErr) begin
        n_t++;
        if (t_at < 0 && !bus_a.busy) t_at = i;
      end
    end
    total++;
    if (n_g !== TMO_A) begin
      bad++;
      $display("FAIL timeout_grant_len: got %0d want %0d", n_g, TMO_A);
    end
    total++;
    if (n_t !== 1) begin
      bad++;
      $display("FAIL timeout_err_pulses: got %0d want %0d", n_t, 1);
    end
    total++;
    if (t_at !== TMO_A) begin
      bad++;
      $display("FAIL timeout_err_cycle: got %0d want %0d", t_at, TMO_A);
    end
    drive(1, 1, 0, 0);
    tick;
    total++;
    if (obs_a() !== 7'b0101110) begin
      bad++;
      $display("FAIL timeout_next_grant: got %b want %b", obs_a(), 7'b0101110);
    end
    drive(0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0);
    for (int i = 1; i < TMO_A; i++) tick;
    total++;
    if (obs_a() !== 7'b0101110) begin
      bad++;
      $display("FAIL simul_last_cycle: got %b want %b", obs_a(), 7'b0101110);
    end
    drive(0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0);
    total++;
    if (obs_a() !== 7'b0) begin
      bad++;
      $display("FAIL simul_no_err: got %b want %b", obs_a(), 7'b0);
    end
    tick;
  endtask

  task automatic test_midreset();
    drive(0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0);
    for (int i = 1; i < TMO_A; i++) tick;
    total++;
    if (obs_a() !== 7'b0101110) begin
      bad++;
      $display("FAIL midreset_serving: got %b want %b", obs_a(), 7'b0101110);
    end
    drive(0, 0, 0, 1);
    tick;
    total++;
    if (obs_a() !== 7'b0) begin
      bad++;
      $display("FAIL midreset_cleared: got %b want %b", obs_a(), 7'b0);
    end
    drive(1, 1, 0, 0);
    tick;
    total++;
    if (obs_a() !== 7'b1010110) begin
      bad++;
      $display("FAIL midreset_first_grant: got %b want %b", obs_a(), 7'b1010110);
    end
    drive(0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0);
    tick;
  endtask

  // Reference: who owns the port, how many grant cycles it has used, who won last.
  task automatic test_random();
    int owner, age, last;
    bit terr, r1, r2, mr, rs;
    logic [6:0] exp_v;
    drive(0, 0, 0, 1);
    tick;
    owner = 0; age = 0; last = 2; terr = 0;
    for (int i = 0; i < 400; i++) begin
      r1 = ($urandom_range(0, 2) != 0);
      r2 = ($urandom_range(0, 2) != 0);
      mr = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 49) == 0);
      drive(r1, r2, mr, rs);
      tick;
      if (rs) begin
        owner = 0; age = 0; last = 2; terr = 0;
      end else if (owner == 0) begin
        terr = 0;
        if (r1 && r2) owner = (last == 1) ? 2 : 1;
        else if (r1) owner = 1;
        else if (r2) owner = 2;
        if (owner != 0) begin
          last = owner;
          age  = 1;
        end
      end else if (mr) begin
        owner = 0; terr = 0;
      end else if (age == TMO_A) begin
        owner = 0; terr = 1;
      end else begin
        age++; terr = 0;
      end
      exp_v = {owner == 1, owner == 2, owner == 1, owner == 2, owner != 0, owner != 0, terr};
      total++;
      if (obs_a() !== exp_v) begin
        bad++;
        $display("FAIL random_cycle_%0d: got %b want %b", i, obs_a(), exp_v);
      end
    end
    drive(0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0);
    tick;
  endtask

  task automatic test_nowdog();
    int n_g, n_t;
    n_g = 0; n_t = 0;
    bus_b.req1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      bus_b.req1 = 1'b0;
      if (bus_b.gnt1) n_g++;
      if (bus_b.timeoutErr) n_t++;
    end
    total++;
    if (n_g !== 40) begin
      bad++;
      $display("FAIL nowdog_grant_len: got %0d want %0d", n_g, 40);
    end
    total++;
    if (n_t !== 0) begin
      bad++;
      $display("FAIL nowdog_err: got %0d want %0d", n_t, 0);
    end
    bus_b.memReady = 1'b1;
    tick;
    bus_b.memReady = 1'b0;
    total++;
    if (bus_b.busy !== 1'b0) begin
      bad++;
      $display("FAIL nowdog_release: got %b want %b", bus_b.busy, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    drive(0, 0, 0, 1);
    bus_b.req1     = 1'b0;
    bus_b.req2     = 1'b0;
    bus_b.memReady = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_simultaneous();
    test_midreset();
    test_random();
    test_nowdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
